param_counter: RTL and testbench

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/counter_pkg.sv | 24 ++
 rtl/count_prescaler.sv | 33 +++
 rtl/param_counter.sv | 163 ++++++++++++++++
 tb/tb_param_counter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for param_counter: count modes and ONESHOT FSM states.
package counter_pkg;

   // Mode bus encoding; 2'b11 is reserved and behaves as WRAP.
   typedef enum logic [1:0] {
      MODE_WRAP     = 2'b00,
      MODE_SATURATE = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_WRAP_ALT = 2'b11
   } mode_e;

   // ONESHOT run sequencing.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // True when the raw mode bus selects a ONESHOT run.
   function automatic logic is_oneshot(input logic [1:0] m);
      return (m == MODE_ONESHOT);
   endfunction

endpackage

// File: rtl/count_prescaler.sv
// Enable prescaler for param_counter: emits one tick per PRESCALE en-high
// cycles. Only instantiated when PARAM_COUNTER_PRESCALE_EN is defined.
module count_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   // PRESCALE=1 still needs a one-bit counter; it simply never leaves zero.
   localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == LAST);
   assign tick   = en && w_last;

   // Count en-high cycles, rolling over on the tick cycle.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_cnt <= '0;
      end else if (en) begin
         if (w_last) r_cnt <= '0;
         else        r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/param_counter.sv
// Parameterized up/down counter with WRAP, SATURATE and ONESHOT modes,
// parallel load and a registered terminal-count pulse.
// Optional feature macro: PARAM_COUNTER_PRESCALE_EN -- when defined, count
// steps are taken once per PRESCALE en-high cycles instead of on every en.
module param_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_value,
   input  logic             up,
   input  logic [WIDTH-1:0] limit,
   input  logic [1:0]       mode,
   input  logic             start,
   output logic [WIDTH-1:0] dout,
   output logic             tc,
   output logic             busy
);

   // Reject illegal configurations at elaboration.
   if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 1 || PRESCALE > 256) begin : g_bad_param
      $error("param_counter: WIDTH must be 2..32 and PRESCALE 1..256");
   end

   logic [WIDTH-1:0] r_dout;
   logic             r_tc;
   state_e           r_state;

   logic             w_tick;
   logic             w_oneshot;
   logic             w_start_ok;
   logic [WIDTH-1:0] w_inc;
   logic [WIDTH-1:0] w_dec;
   logic             w_at_top;
   logic             w_at_zero;
   logic [WIDTH-1:0] w_step_val;
   logic             w_step_term;

`ifdef PARAM_COUNTER_PRESCALE_EN
   // ld and start restart the prescale window so the first step after them
   // is a full PRESCALE en-cycles away.
   count_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (ld | start),
      .en    (en),
      .tick  (w_tick)
   );
`else
   assign w_tick = en;
`endif

   assign w_oneshot  = is_oneshot(mode);
   assign w_start_ok = start && w_oneshot && (r_state != ST_RUN);
   assign w_inc      = r_dout + WIDTH'(1);
   assign w_dec      = r_dout - WIDTH'(1);
   assign w_at_top   = (r_dout >= limit);
   assign w_at_zero  = (r_dout == '0);

   // Next count value and terminal flag for a step in the current mode.
   // A held (already saturated) step is not terminal; a ONESHOT step that
   // starts at or beyond its bound is terminal so the run always ends.
   always_comb begin
      w_step_val  = r_dout;
      w_step_term = 1'b0;
      case (mode)
         MODE_SATURATE: begin
            if (up) begin
               if (w_at_top) begin
                  w_step_val = limit;
               end else begin
                  w_step_val  = w_inc;
                  w_step_term = (w_inc == limit);
               end
            end else if (!w_at_zero) begin
               w_step_val  = w_dec;
               w_step_term = (w_dec == '0);
            end
         end
         MODE_ONESHOT: begin
            if (up) begin
               if (w_at_top) begin
                  w_step_val  = limit;
                  w_step_term = 1'b1;
               end else begin
                  w_step_val  = w_inc;
                  w_step_term = (w_inc == limit);
               end
            end else begin
               if (w_at_zero) begin
                  w_step_term = 1'b1;
               end else begin
                  w_step_val  = w_dec;
                  w_step_term = (w_dec == '0);
               end
            end
         end
         default: begin
            // WRAP and the reserved encoding.
            if (up) begin
               if (w_at_top) begin
                  w_step_val  = '0;
                  w_step_term = 1'b1;
               end else begin
                  w_step_val = w_inc;
               end
            end else begin
               if (w_at_zero) begin
                  w_step_val  = limit;
                  w_step_term = 1'b1;
               end else begin
                  w_step_val = w_dec;
               end
            end
         end
      endcase
   end

   // Counter and ONESHOT FSM: reset > ld > start > step. tc is cleared every
   // cycle and only set by a terminal step, making it a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout  <= '0;
         r_tc    <= 1'b0;
         r_state <= ST_IDLE;
      end else begin
         r_tc <= 1'b0;
         if (ld) begin
            r_dout <= ld_value;
         end else if (w_start_ok) begin
            r_state <= ST_RUN;
            r_dout  <= up ? '0 : limit;
         end else if (w_tick) begin
            if (w_oneshot) begin
               if (r_state == ST_RUN) begin
                  r_dout <= w_step_val;
                  if (w_step_term) begin
                     r_state <= ST_DONE;
                     r_tc    <= 1'b1;
                  end
               end
            end else begin
               r_dout <= w_step_val;
               r_tc   <= w_step_term;
            end
         end
         // Leaving ONESHOT abandons any run regardless of other strobes.
         if (!w_oneshot) r_state <= ST_IDLE;
      end
   end

   assign dout = r_dout;
   assign tc   = r_tc;
   assign busy = (r_state == ST_RUN);

endmodule

// File: tb/tb_param_counter.sv
// Table-driven bench for param_counter (WIDTH=4, PRESCALE=4).
module tb_param_counter;

   localparam int W = 4;
   localparam int P = 4;
`ifdef PARAM_COUNTER_PRESCALE_EN
   localparam int TPS = P;
`else
   localparam int TPS = 1;
`endif

   logic         clk = 1'b0;
   logic         reset, en, ld, up, start;
   logic [W-1:0] ld_value, limit, dout;
   logic [1:0]   mode;
   logic         tc, busy;

   always #5 clk = ~clk;

   param_counter #(.WIDTH(W), .PRESCALE(P)) dut (
      .clk(clk), .reset(reset), .en(en), .ld(ld), .ld_value(ld_value),
      .up(up), .limit(limit), .mode(mode), .start(start),
      .dout(dout), .tc(tc), .busy(busy)
   );

   typedef struct {
      string        tag;
      logic         rst, ld, st, en, up;
      logic [W-1:0] ldv, lim;
      logic [1:0]   md;
      logic [W-1:0] e_dout;
      logic         e_tc, e_busy;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input string tag, input int rst, input int l, input int ldv,
                      input int st, input int e, input int u, input int lim,
                      input int md, input int ed, input int etc, input int eb);
      vec_t v;
      v.tag = tag; v.rst = rst[0]; v.ld = l[0]; v.ldv = W'(ldv); v.st = st[0];
      v.en = e[0]; v.up = u[0]; v.lim = W'(lim); v.md = 2'(md);
      v.e_dout = W'(ed); v.e_tc = etc[0]; v.e_busy = eb[0];
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst; ld = v.ld; ld_value = v.ldv; start = v.st; en = v.en;
      up = v.up; limit = v.lim; mode = v.md;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s [vec %0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   initial begin
      int   cyc;
      bit   seen;
      vec_t v;

      // tag, rst, ld, ldv, st, en, up, lim, md, exp dout, exp tc, exp busy
      add("reset",        1,0,0, 0,0,1, 9,0,  0,0,0);
      add("reset_ovr",    1,1,7, 1,1,1, 9,0,  0,0,0);
`ifndef PARAM_COUNTER_PRESCALE_EN
      for (int i = 1; i <= 9; i++) add("wrap_up", 0,0,0, 0,1,1, 9,0, i,0,0);
      add("wrap_up_tc",   0,0,0, 0,1,1, 9,0,  0,1,0);
      add("wrap_up",      0,0,0, 0,1,1, 9,0,  1,0,0);
      add("en_low_hold",  0,0,0, 0,0,1, 9,0,  1,0,0);
      add("wrap_dn_ld",   0,1,2, 0,0,0, 5,0,  2,0,0);
      add("wrap_dn",      0,0,0, 0,1,0, 5,0,  1,0,0);
      add("wrap_dn",      0,0,0, 0,1,0, 5,0,  0,0,0);
      add("wrap_dn_tc",   0,0,0, 0,1,0, 5,0,  5,1,0);
      add("wrap_dn",      0,0,0, 0,1,0, 5,0,  4,0,0);
      add("wrap_hi_ld",   0,1,12,0,0,1, 5,0, 12,0,0);
      add("wrap_hi",      0,0,0, 0,1,1, 5,0,  0,1,0);
      add("lim0_up",      0,0,0, 0,1,1, 0,0,  0,1,0);
      add("lim0_up",      0,0,0, 0,1,1, 0,0,  0,1,0);
      add("lim0_dn",      0,0,0, 0,1,0, 0,0,  0,1,0);
      add("mode3_ld",     0,1,1, 0,0,1, 2,3,  1,0,0);
      add("mode3",        0,0,0, 0,1,1, 2,3,  2,0,0);
      add("mode3_tc",     0,0,0, 0,1,1, 2,3,  0,1,0);
      add("ld_at_bound",  0,1,9, 0,0,1, 9,0,  9,0,0);
      add("ld_beats_step",0,1,9, 0,1,1, 9,0,  9,0,0);
      add("sat_ld",       0,1,13,0,0,1,15,1, 13,0,0);
      add("sat_up",       0,0,0, 0,1,1,15,1, 14,0,0);
      add("sat_up_tc",    0,0,0, 0,1,1,15,1, 15,1,0);
      add("sat_hold",     0,0,0, 0,1,1,15,1, 15,0,0);
      add("sat_hold",     0,0,0, 0,1,1,15,1, 15,0,0);
      add("sat_dn_ld",    0,1,1, 0,0,0,15,1,  1,0,0);
      add("sat_dn_tc",    0,0,0, 0,1,0,15,1,  0,1,0);
      add("sat_dn_hold",  0,0,0, 0,1,0,15,1,  0,0,0);
      add("os_start",     0,0,0, 1,1,1, 3,2,  0,0,1);
      add("os_run",       0,0,0, 0,1,1, 3,2,  1,0,1);
      add("os_run",       0,0,0, 0,1,1, 3,2,  2,0,1);
      add("os_done_tc",   0,0,0, 0,1,1, 3,2,  3,1,0);
      add("os_done_hold", 0,0,0, 0,1,1, 3,2,  3,0,0);
      add("os_done_hold", 0,0,0, 0,1,1, 3,2,  3,0,0);
      add("os_dn_start",  0,0,0, 1,0,0, 3,2,  3,0,1);
      add("os_dn",        0,0,0, 0,1,0, 3,2,  2,0,1);
      add("os_dn",        0,0,0, 0,1,0, 3,2,  1,0,1);
      add("os_dn_tc",     0,0,0, 0,1,0, 3,2,  0,1,0);
      add("os_restart",   0,0,0, 1,0,1, 3,2,  0,0,1);
      add("os_start_ign", 0,0,0, 1,1,1, 3,2,  1,0,1);
      add("os_ld_in_run", 0,1,0, 0,1,1, 3,2,  0,0,1);
      add("os_run",       0,0,0, 0,1,1, 3,2,  1,0,1);
      add("os_run",       0,0,0, 0,1,1, 3,2,  2,0,1);
      add("os_rst_ld",    1,1,7, 0,1,1, 3,2,  0,0,0);
      add("os_restart",   0,0,0, 1,0,1, 3,2,  0,0,1);
      add("os_run",       0,0,0, 0,1,1, 3,2,  1,0,1);
      add("os_exit_mode", 0,0,0, 0,0,1, 3,0,  1,0,0);
      add("os_idle_hold", 0,0,0, 0,1,1, 3,2,  1,0,0);
`else
      for (int i = 1; i <= 12; i++) add("pre_wrap", 0,0,0, 0,1,1,15,0, i/4,0,0);
      add("pre_ld",       0,1,0, 0,1,1,15,0,  0,0,0);
      for (int i = 1; i <= 4; i++) add("pre_after_ld", 0,0,0, 0,1,1,15,0, i/4,0,0);
`endif

      foreach (vecs[i]) begin
         v = vecs[i];
         drive(v);
         chk({v.tag, ".dout"}, i, int'(dout), int'(v.e_dout));
         chk({v.tag, ".tc"},   i, int'(tc),   int'(v.e_tc));
         chk({v.tag, ".busy"}, i, int'(busy), int'(v.e_busy));
      end

      // Long ONESHOT run: tc must arrive after exactly 9 steps and stay single.
      reset = 1'b0; ld = 1'b0; en = 1'b0; up = 1'b1; limit = 4'd9; mode = 2'b10;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; en = 1'b1;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         seen = tc;
      end
      chk("os_long.timeout", 0, int'(seen), 1);
      chk("os_long.cycles",  0, cyc, 9 * TPS);
      chk("os_long.dout",    0, int'(dout), 9);
      chk("os_long.busy",    0, int'(busy), 0);
      @(posedge clk); #1;
      chk("os_long.tc_once", 0, int'(tc), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
